// File: rtl/pe_array_3x3_os.sv
// ---------------------------------------------------------------------------
// pe_array_3x3_os
//
// Output-stationary 3x3 systolic array computing C = A x B in signed 16.16
// fixed point. Rows of A enter from the left and columns of B enter from the
// top. Each lane is skewed by one cycle. Every PE keeps its own C element in a
// local accumulator. A shift_acc pulse snapshots all nine accumulators into a
// 9-entry shift register and clears them. The results are then drained one
// word per cycle in reverse row-major order: PE(2,2) first, PE(0,0) last.
//
// Ports
//   clock      : sole clock, rising edge
//   resetn     : asynchronous reset, active high (asserted = 1)
//   iact_in    : iact_in[i] is the A element entering row i
//   weight_in  : weight_in[j] is the B element entering column j
//   in_valid   : in_valid[n] qualifies both iact_in[n] and weight_in[n]
//   shift_acc  : one-cycle pulse that starts a readout of all nine results
//   data_out   : serial 16.16 result word, 0 when idle
//   out_valid  : high for exactly nine cycles per readout
// ---------------------------------------------------------------------------
module pe_array_3x3_os (
    input  logic             clock,
    input  logic             resetn,
    input  logic [2:0][31:0] iact_in,
    input  logic [2:0][31:0] weight_in,
    input  logic [2:0]       in_valid,
    input  logic             shift_acc,
    output logic [31:0]      data_out,
    output logic             out_valid
);

    // Per-PE accumulators
    logic [31:0] acc_q [3][3];
    logic [31:0] acc_d [3][3];

    // Forwarding registers. The rightmost column's iact and the bottom row's
    // weight have no consumer, so only the links that feed a neighbour exist.
    logic [31:0] iactFwd_q [3][2];
    logic        iactVld_q [3][2];
    logic [31:0] wgtFwd_q  [2][3];
    logic        wgtVld_q  [2][3];

    // Operands as seen by each PE this cycle
    logic [31:0] peIact    [3][3];
    logic        peIactVld [3][3];
    logic [31:0] peWgt     [3][3];
    logic        peWgtVld  [3][3];

    // Readout state
    logic [31:0] outShift_q [9];
    logic [3:0]  wordCnt_q;
    logic        outValid_q;
    logic        startRead;

    // 16.16 multiply: full signed 64-bit product, keep bits [47:16] (truncate).
    function automatic logic [31:0] fxMul(input logic [31:0] a, input logic [31:0] b);
        return 32'(({{32{a[31]}}, a} * {{32{b[31]}}, b}) >> 16);
    endfunction

    // wordCnt_q counts the words still to come after the current one. It is
    // zero both when idle and on the last word, so a new pulse is accepted on
    // the edge where out_valid falls.
    assign startRead = shift_acc && (wordCnt_q == 4'd0);

    // Edge PEs take the array inputs directly. Inner PEs take their
    // neighbour's forwarded copy.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            peIact[i][0]    = iact_in[i];
            peIactVld[i][0] = in_valid[i];
            for (int j = 1; j < 3; j++) begin
                peIact[i][j]    = iactFwd_q[i][j-1];
                peIactVld[i][j] = iactVld_q[i][j-1];
            end
        end
        for (int j = 0; j < 3; j++) begin
            peWgt[0][j]    = weight_in[j];
            peWgtVld[0][j] = in_valid[j];
            for (int i = 1; i < 3; i++) begin
                peWgt[i][j]    = wgtFwd_q[i-1][j];
                peWgtVld[i][j] = wgtVld_q[i-1][j];
            end
        end
    end

    // Accumulator next state. A readout clears the accumulator first, so a
    // product arriving in the same cycle starts the next result.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_d[i][j] = startRead ? 32'd0 : acc_q[i][j];
                if (peIactVld[i][j] && peWgtVld[i][j]) begin
                    acc_d[i][j] = acc_d[i][j] + fxMul(peIact[i][j], peWgt[i][j]);
                end
            end
        end
    end

    // PE array registers: accumulators plus forwarding of every operand and
    // valid each cycle, whether or not the operand is valid.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= '0;
                end
                for (int j = 0; j < 2; j++) begin
                    iactFwd_q[i][j] <= '0;
                    iactVld_q[i][j] <= 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 3; j++) begin
                    wgtFwd_q[i][j] <= '0;
                    wgtVld_q[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= acc_d[i][j];
                end
                for (int j = 0; j < 2; j++) begin
                    iactFwd_q[i][j] <= peIact[i][j];
                    iactVld_q[i][j] <= peIactVld[i][j];
                end
            end
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 3; j++) begin
                    wgtFwd_q[i][j] <= peWgt[i][j];
                    wgtVld_q[i][j] <= peWgtVld[i][j];
                end
            end
        end
    end

    // Readout shift register. Entry 0 drives data_out. Zeros are shifted in
    // from the top, so the register is all zero again once the last word has
    // been shifted out, and data_out returns to 0 by itself.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int k = 0; k < 9; k++) begin
                outShift_q[k] <= '0;
            end
            wordCnt_q  <= '0;
            outValid_q <= 1'b0;
        end else if (startRead) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    outShift_q[8 - (3 * i + j)] <= acc_q[i][j];
                end
            end
            wordCnt_q  <= 4'd8;
            outValid_q <= 1'b1;
        end else if (outValid_q) begin
            for (int k = 0; k < 8; k++) begin
                outShift_q[k] <= outShift_q[k+1];
            end
            outShift_q[8] <= '0;
            if (wordCnt_q == 4'd0) begin
                outValid_q <= 1'b0;
            end else begin
                wordCnt_q <= wordCnt_q - 4'd1;
            end
        end
    end

    assign data_out  = outShift_q[0];
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_pe_array_3x3_os.sv
// ---------------------------------------------------------------------------
// tb_pe_array_3x3_os
//
// Directed and randomized bench for pe_array_3x3_os. The reference model
// treats the array as a timing rule. An A word entering lane i at cycle t
// reaches PE(i,j) at cycle t+j. A B word entering lane j at cycle t reaches
// PE(i,j) at cycle t+i. The PE accumulates the 16.16 product when both words
// meet there with their valids set.
// ---------------------------------------------------------------------------
module tb_pe_array_3x3_os;

    logic             clock;
    logic             resetn;
    logic [2:0][31:0] iact_in;
    logic [2:0][31:0] weight_in;
    logic [2:0]       in_valid;
    logic             shift_acc;
    logic [31:0]      data_out;
    logic             out_valid;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [31:0] modelAcc [3][3];
    logic [31:0] matA [3][3];
    logic [31:0] matB [3][3];
    logic [31:0] laneA [8][3];
    logic [31:0] laneB [8][3];
    logic [2:0]  laneV [8];
    int          burstLen;
    logic [31:0] expWords [9];

    pe_array_3x3_os dut (
        .clock     (clock),
        .resetn    (resetn),
        .iact_in   (iact_in),
        .weight_in (weight_in),
        .in_valid  (in_valid),
        .shift_acc (shift_acc),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference 16.16 multiply: exact signed product, truncated toward -inf
    function automatic logic [31:0] fxMul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 32'(p >>> 16);
    endfunction

    function automatic logic [31:0] fx(input int whole);
        return 32'(whole) << 16;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of lane inputs, then step to just after the edge
    task automatic applyStimulus(input int c);
        for (int n = 0; n < 3; n++) begin
            if (c < burstLen) begin
                in_valid[n]  = laneV[c][n];
                iact_in[n]   = laneA[c][n];
                weight_in[n] = laneB[c][n];
            end else begin
                in_valid[n]  = 1'b0;
                iact_in[n]   = '0;
                weight_in[n] = '0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            in_valid  = '0;
            iact_in   = '0;
            weight_in = '0;
            @(posedge clock);
            #1;
        end
    endtask

    // Standard skewed feed of matA/matB. Invalid slots carry junk data.
    task automatic loadSkewed();
        burstLen = 5;
        for (int c = 0; c < 5; c++) begin
            for (int n = 0; n < 3; n++) begin
                int k;
                k = c - n;
                if (k >= 0 && k <= 2) begin
                    laneV[c][n] = 1'b1;
                    laneA[c][n] = matA[n][k];
                    laneB[c][n] = matB[k][n];
                end else begin
                    laneV[c][n] = 1'b0;
                    laneA[c][n] = $urandom;
                    laneB[c][n] = $urandom;
                end
            end
        end
    endtask

    // Arbitrary lane traffic, including valids with no partner
    task automatic loadRandomLanes();
        burstLen = 8;
        for (int c = 0; c < 8; c++) begin
            laneV[c] = 3'($urandom);
            for (int n = 0; n < 3; n++) begin
                laneA[c][n] = $urandom;
                laneB[c][n] = $urandom;
            end
        end
    endtask

    task automatic modelUpdate();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                for (int t = 0; t < burstLen + 3; t++) begin
                    int ac;
                    int bc;
                    ac = t - j;
                    bc = t - i;
                    if (ac >= 0 && ac < burstLen && bc >= 0 && bc < burstLen) begin
                        if (laneV[ac][i] && laneV[bc][j]) begin
                            modelAcc[i][j] = modelAcc[i][j] + fxMul(laneA[ac][i], laneB[bc][j]);
                        end
                    end
                end
            end
        end
    endtask

    // Feed the burst, then leave three idle cycles so the readout pulse lands
    // after the last product has reached PE(2,2).
    task automatic runBurst();
        for (int c = 0; c < burstLen; c++) begin
            applyStimulus(c);
        end
        idle(3);
        modelUpdate();
    endtask

    task automatic expectFromModel();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                expWords[8 - (3 * i + j)] = modelAcc[i][j];
                modelAcc[i][j] = '0;
            end
        end
    endtask

    task automatic readOut(input string tag, input bit rePulse);
        shift_acc = 1'b1;
        @(posedge clock);
        #1;
        shift_acc = 1'b0;
        for (int w = 0; w < 9; w++) begin
            checkOutput($sformatf("%s_valid%0d", tag, w), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("%s_word%0d", tag, w), data_out, expWords[w]);
            if (w < 8) begin
                if (rePulse && w == 2) shift_acc = 1'b1;
                @(posedge clock);
                #1;
                shift_acc = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        checkOutput({tag, "_validEnd"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_dataEnd"}, data_out, 32'd0);
        if (rePulse) begin
            @(posedge clock);
            #1;
            checkOutput({tag, "_noRestart"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic randomMats();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                matA[i][j] = $urandom;
                matB[i][j] = $urandom;
            end
        end
    endtask

    initial begin
        resetn    = 1'b1;
        shift_acc = 1'b0;
        in_valid  = '0;
        iact_in   = '0;
        weight_in = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                modelAcc[i][j] = '0;
            end
        end

        // Reset held, then released with no stimulus
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstData", data_out, 32'd0);
        resetn = 1'b0;
        idle(3);
        checkOutput("idleValid", {31'd0, out_valid}, 32'd0);
        checkOutput("idleData", data_out, 32'd0);

        // Directed matrix product, expected words taken from the known result
        matA[0][0] = fx(2); matA[0][1] = fx(3); matA[0][2] = fx(8);
        matA[1][0] = fx(6); matA[1][1] = fx(2); matA[1][2] = fx(5);
        matA[2][0] = fx(2); matA[2][1] = fx(3); matA[2][2] = fx(3);
        matB[0][0] = fx(1); matB[0][1] = fx(2);       matB[0][2] = fx(3);
        matB[1][0] = fx(4); matB[1][1] = 32'h0007_8000; matB[1][2] = fx(2);
        matB[2][0] = fx(1); matB[2][1] = fx(4);       matB[2][2] = fx(4);
        loadSkewed();
        runBurst();
        expectFromModel();
        expWords[0] = 32'h0018_0000;
        expWords[1] = 32'h0026_8000;
        expWords[2] = 32'h0011_0000;
        expWords[3] = 32'h002A_0000;
        expWords[4] = 32'h002F_0000;
        expWords[5] = 32'h0013_0000;
        expWords[6] = 32'h002C_0000;
        expWords[7] = 32'h003A_8000;
        expWords[8] = 32'h0016_0000;
        readOut("mat", 1'b0);

        // Second readout with no new inputs: accumulators were cleared
        idle(2);
        expectFromModel();
        readOut("clr", 1'b0);

        // Identity times a matrix holding only -1.5 in B[0][0]
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                matA[i][j] = (i == j) ? fx(1) : 32'd0;
                matB[i][j] = '0;
            end
        end
        matB[0][0] = 32'hFFFE_8000;
        loadSkewed();
        runBurst();
        expectFromModel();
        expWords[8] = 32'hFFFE_8000;
        readOut("sgn", 1'b0);

        // Random product, with a second pulse during the readout that must be ignored
        randomMats();
        loadSkewed();
        runBurst();
        expectFromModel();
        readOut("busy", 1'b1);

        // Random lane traffic with unpartnered valids
        for (int r = 0; r < 2; r++) begin
            loadRandomLanes();
            runBurst();
            expectFromModel();
            readOut($sformatf("rnd%0d", r), 1'b0);
        end

        // Reset in the middle of a readout
        randomMats();
        loadSkewed();
        runBurst();
        expectFromModel();
        shift_acc = 1'b1;
        @(posedge clock);
        #1;
        shift_acc = 1'b0;
        for (int w = 0; w < 4; w++) begin
            checkOutput($sformatf("abort_word%0d", w), data_out, expWords[w]);
            if (w < 3) begin
                @(posedge clock);
                #1;
            end
        end
        #1;
        resetn = 1'b1;
        #1;
        checkOutput("abortValid", {31'd0, out_valid}, 32'd0);
        checkOutput("abortData", data_out, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        idle(2);
        expectFromModel();
        readOut("postRst", 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
